dcache: RTL and testbench
=========================

# dcache

Direct-mapped, write-back, write-allocate data cache sitting between the CPU's load/store path and the 32-bit-block data memory. It answers CPU byte accesses in the same cycle on a hit. On a miss it stalls the CPU through BUSY_WAIT while it writes back a dirty victim and fetches the missing block.

## Interface
- No parameters; geometry fixed: 8 lines × 4 bytes, 8-bit byte address = tag[7:5] | index[4:2] | offset[1:0].
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  reset RESET, synchronous, active-high.
- READ  input  1  CPU load request, held until BUSY_WAIT low.
- WRITE  input  1  CPU store request, held until BUSY_WAIT low; READ and WRITE never both high.
- ADDRESS  input  8  CPU byte address (ALU result).
- WRITEDATA  input  8  store byte.
- READDATA  output  8  load byte.
- BUSY_WAIT  output  1  CPU stall; PC and register write are suppressed while high.
- MEM_READ  output  1  block fetch request.
- MEM_WRITE  output  1  block write-back request.
- MEM_ADDRESS  output  6  block address {tag,index}.
- MEM_WRITEDATA  output  32  victim block, byte 0 in bits [7:0].
- MEM_READDATA  input  32  fetched block, byte 0 in bits [7:0].
- MEM_BUSYWAIT  input  1  memory busy; raised no earlier than the cycle after a request.

## Operation
- Per line state: valid, dirty, 3-bit tag, 32-bit data.
- HIT = valid[index] & (tag[index] == ADDRESS[7:5]), combinational.
- READDATA = byte ADDRESS[1:0] of data[index], combinational, always driven.
- BUSY_WAIT = (state != IDLE) | ((READ | WRITE) & !HIT).
- FSM states:
  - IDLE: MEM_READ = MEM_WRITE = 0.
    - Write hit: at the edge, store WRITEDATA into byte offset and set dirty.
    - Read hit: no state change.
    - Miss with victim valid & dirty: go to WRITEBACK.
    - Miss otherwise: go to FETCH.
    - No request: stay.
  - WRITEBACK: MEM_WRITE = 1, MEM_ADDRESS = {tag[index], index}, MEM_WRITEDATA = data[index].
  - FETCH: MEM_READ = 1, MEM_ADDRESS = ADDRESS[7:2].
- Completion rule for WRITEBACK and FETCH: an internal issued flag is set on the first cycle in the state. The state completes on an edge where issued = 1 and MEM_BUSYWAIT = 0. This means the earliest completion is the second cycle in the state.
  - WRITEBACK completion: go to FETCH and clear issued.
  - FETCH completion: load MEM_READDATA, tag = ADDRESS[7:5], valid = 1, dirty = 0; go to IDLE.
- After FETCH the access re-evaluates in IDLE as a hit. Write misses complete through the normal write-hit path, so dirty is set by the store.
- MEM_WRITEDATA is 0 outside WRITEBACK; MEM_ADDRESS is 0 in IDLE.
- Write allocate: a store miss fetches the block before the byte merge.

## Timing
- Reset, synchronous to CLK:
  - state = IDLE, issued = 0; all valid, dirty, tag and data cleared.
  - Outputs after reset: MEM_READ = 0, MEM_WRITE = 0, MEM_ADDRESS = 0, MEM_WRITEDATA = 0.
  - READDATA = 0.
  - BUSY_WAIT = 1 only if a request is present, because every line misses.
- RESET asserted mid-miss aborts the memory transaction at that edge. The line being fetched stays invalid.
- Hit latency: 0 stall cycles. A store hit commits at the same edge the CPU advances PC.
- Clean miss stall: 1 cycle (IDLE→FETCH edge) + FETCH cycles (≥2) + 1 IDLE hit cycle. BUSY_WAIT falls in that final IDLE cycle.
- Dirty miss stall: adds the WRITEBACK cycles (≥2).
- Memory request signals are held constant for the whole state. They drop the cycle after completion.
- ADDRESS, READ and WRITE must be stable while BUSY_WAIT is high. This is guaranteed by the CPU stall.
- Same-index conflict (tag differs) evicts; it is not treated as a hit.

## Test plan
- Reset then READ ADDRESS=0x05, memory block 1 = 0x44332211 with 3-cycle busy → MEM_READ with MEM_ADDRESS=0x01; BUSY_WAIT high until the IDLE re-check; then READDATA=0x22; MEM_WRITE never asserted.
- Preload per the previous test, then WRITE 0xAA to 0x06 → no stall; following READ 0x06 returns 0xAA with no stall; line 1 dirty.
- Line 1 dirty, READ 0x25 (same index, tag 1) → WRITEBACK first with MEM_ADDRESS=0x01, MEM_WRITEDATA=0x44AA2211; then FETCH with MEM_ADDRESS=0x09.
- Write miss to clean line 0x10 with WRITEDATA 0x5C → FETCH, then merge; READ 0x10 returns 0x5C and the remaining bytes match memory.
- RESET asserted during FETCH → next cycle MEM_READ=0, BUSY_WAIT reflects a fresh miss, all lines invalid.
- MEM_BUSYWAIT held low throughout (instant memory) → FETCH still lasts exactly 2 cycles; the clean read miss stalls 4 cycles total.

Source files
------------

// File: rtl/dcache_if.sv
// CPU load/store and block-memory signals of the data cache, bundled as one interface.
interface dcache_if;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSY_WAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    modport slave (
        input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        output READDATA, BUSY_WAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );

    modport master (
        output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        input  READDATA, BUSY_WAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );
endinterface

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines of 4 bytes, single-cycle hits,
// CPU stalled through BUSY_WAIT while a dirty victim is written back and the missing block fetched.
module dcache (
    input logic     CLK,
    input logic     RESET,
    dcache_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StWriteback, StFetch} state_e;

    state_e state_q, state_d;
    logic   issued_q, issued_d;

    logic [7:0]  valid_q;
    logic [7:0]  dirty_q;
    logic [2:0]  tag_q  [8];
    logic [31:0] data_q [8];

    logic [2:0] addr_tag;
    logic [2:0] addr_idx;
    logic [1:0] addr_off;
    logic       request;
    logic       hit;
    logic       mem_done;
    logic       write_hit;
    logic       fill;

    assign addr_tag  = bus.ADDRESS[7:5];
    assign addr_idx  = bus.ADDRESS[4:2];
    assign addr_off  = bus.ADDRESS[1:0];
    assign request   = bus.READ | bus.WRITE;
    assign hit       = valid_q[addr_idx] & (tag_q[addr_idx] == addr_tag);
    // The memory may only raise its busy flag the cycle after a request, so the first cycle
    // in a memory state never completes.
    assign mem_done  = issued_q & ~bus.MEM_BUSYWAIT;
    assign write_hit = (state_q == StIdle) & bus.WRITE & hit;
    assign fill      = (state_q == StFetch) & mem_done;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= StIdle;
            issued_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        issued_d = issued_q;
        unique case (state_q)
            StIdle: begin
                issued_d = 1'b0;
                if (request && !hit) begin
                    state_d = (valid_q[addr_idx] && dirty_q[addr_idx]) ? StWriteback : StFetch;
                end
            end
            StWriteback: begin
                issued_d = 1'b1;
                if (mem_done) begin
                    state_d  = StFetch;
                    issued_d = 1'b0;
                end
            end
            StFetch: begin
                issued_d = 1'b1;
                if (mem_done) begin
                    state_d  = StIdle;
                    issued_d = 1'b0;
                end
            end
            default: begin
                state_d  = StIdle;
                issued_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        bus.MEM_READ      = 1'b0;
        bus.MEM_WRITE     = 1'b0;
        bus.MEM_ADDRESS   = '0;
        bus.MEM_WRITEDATA = '0;
        unique case (state_q)
            StWriteback: begin
                bus.MEM_WRITE     = 1'b1;
                bus.MEM_ADDRESS   = {tag_q[addr_idx], addr_idx};
                bus.MEM_WRITEDATA = data_q[addr_idx];
            end
            StFetch: begin
                bus.MEM_READ    = 1'b1;
                bus.MEM_ADDRESS = bus.ADDRESS[7:2];
            end
            default: ;
        endcase
    end

    assign bus.READDATA  = data_q[addr_idx][{addr_off, 3'b000} +: 8];
    assign bus.BUSY_WAIT = (state_q != StIdle) | (request & ~hit);

    // A store miss falls through to the write-hit path once the fetched line is in place.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < 8; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (fill) begin
            valid_q[addr_idx] <= 1'b1;
            dirty_q[addr_idx] <= 1'b0;
            tag_q[addr_idx]   <= addr_tag;
            data_q[addr_idx]  <= bus.MEM_READDATA;
        end else if (write_hit) begin
            data_q[addr_idx][{addr_off, 3'b000} +: 8] <= bus.WRITEDATA;
            dirty_q[addr_idx] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache: a byte-level memory model predicts load data, write-backs and fetches.
module tb_dcache;
    logic CLK = 1'b0;
    logic RESET = 1'b1;

    dcache_if bus ();

    dcache u_dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Block memory responder; mem_lat < 0 picks a random busy length per transaction.
    logic [31:0] mem [64];
    int          mem_lat = -1;
    int          busy_left = 0;
    int          cur_op = 0;
    int          prev_op = 0;

    initial begin
        bus.MEM_BUSYWAIT = 1'b0;
        bus.MEM_READDATA = '0;
        forever begin
            @(posedge CLK);
            #1;
            cur_op = bus.MEM_WRITE ? 2 : (bus.MEM_READ ? 1 : 0);
            if (cur_op == 0) begin
                bus.MEM_BUSYWAIT = 1'b0;
            end else if (cur_op != prev_op) begin
                busy_left = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
                bus.MEM_BUSYWAIT = 1'b0;
            end else if (busy_left > 0) begin
                bus.MEM_BUSYWAIT = 1'b1;
                busy_left--;
            end else begin
                bus.MEM_BUSYWAIT = 1'b0;
            end
            if (bus.MEM_WRITE) mem[bus.MEM_ADDRESS] = bus.MEM_WRITEDATA;
            bus.MEM_READDATA = bus.MEM_READ ? mem[bus.MEM_ADDRESS] : 32'h0;
            prev_op = cur_op;
        end
    end

    // Reference: the CPU sees one coherent byte array; the cache only decides which
    // block transfers happen.
    logic [7:0] arch [256];
    bit         ref_valid [8];
    bit         ref_dirty [8];
    int         ref_tag   [8];

    logic [5:0]  wb_addr_q [$];
    logic [31:0] wb_data_q [$];
    logic [5:0]  fetch_q   [$];
    logic [7:0]  rd_q      [$];

    function automatic void model_reset();
        for (int b = 0; b < 64; b++)
            for (int k = 0; k < 4; k++) arch[b * 4 + k] = mem[b][k * 8 +: 8];
        for (int i = 0; i < 8; i++) begin
            ref_valid[i] = 0;
            ref_dirty[i] = 0;
            ref_tag[i]   = 0;
        end
    endfunction

    function automatic void model_access(input bit wr, input logic [7:0] a, input logic [7:0] wd);
        int idx;
        int tag;
        int vb;
        idx = int'(a[4:2]);
        tag = int'(a[7:5]);
        if (!(ref_valid[idx] && ref_tag[idx] == tag)) begin
            if (ref_valid[idx] && ref_dirty[idx]) begin
                vb = ref_tag[idx] * 8 + idx;
                wb_addr_q.push_back(6'(vb));
                wb_data_q.push_back({arch[vb * 4 + 3], arch[vb * 4 + 2],
                                     arch[vb * 4 + 1], arch[vb * 4]});
            end
            fetch_q.push_back(a[7:2]);
            ref_valid[idx] = 1;
            ref_dirty[idx] = 0;
            ref_tag[idx]   = tag;
        end
        if (wr) begin
            arch[a] = wd;
            ref_dirty[idx] = 1;
        end else begin
            rd_q.push_back(arch[a]);
        end
    endfunction

    // Monitor: compares every transfer and load retirement against the queues.
    int          mem_rd_cycles = 0;
    int          mem_wr_cycles = 0;
    logic [5:0]  last_wb_addr = '0;
    logic [31:0] last_wb_data = '0;
    logic [5:0]  last_fetch_addr = '0;
    logic [7:0]  last_rd = '0;

    initial begin
        bit prev_rd;
        bit prev_wr;
        prev_rd = 0;
        prev_wr = 0;
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                if (bus.MEM_READ)  mem_rd_cycles++;
                if (bus.MEM_WRITE) mem_wr_cycles++;
                if (bus.MEM_WRITE && !prev_wr) begin
                    last_wb_addr = bus.MEM_ADDRESS;
                    last_wb_data = bus.MEM_WRITEDATA;
                    check("writeback expected", 32'(wb_addr_q.size() != 0), 1);
                    if (wb_addr_q.size() != 0) begin
                        check("writeback addr", 32'(bus.MEM_ADDRESS), 32'(wb_addr_q.pop_front()));
                        check("writeback data", bus.MEM_WRITEDATA, wb_data_q.pop_front());
                    end
                end
                if (bus.MEM_READ && !prev_rd) begin
                    last_fetch_addr = bus.MEM_ADDRESS;
                    check("fetch expected", 32'(fetch_q.size() != 0), 1);
                    if (fetch_q.size() != 0)
                        check("fetch addr", 32'(bus.MEM_ADDRESS), 32'(fetch_q.pop_front()));
                end
                if (bus.READ && !bus.BUSY_WAIT) begin
                    last_rd = bus.READDATA;
                    check("load expected", 32'(rd_q.size() != 0), 1);
                    if (rd_q.size() != 0)
                        check("load data", 32'(bus.READDATA), 32'(rd_q.pop_front()));
                end
            end
            prev_rd = bus.MEM_READ;
            prev_wr = bus.MEM_WRITE;
        end
    end

    // Returns the number of cycles from request to retirement (1 = no stall).
    task automatic access(input bit wr, input logic [7:0] a, input logic [7:0] wd,
                          output int cycles);
        model_access(wr, a, wd);
        @(posedge CLK);
        #2;
        bus.READ      = !wr;
        bus.WRITE     = wr;
        bus.ADDRESS   = a;
        bus.WRITEDATA = wd;
        cycles = 0;
        do begin
            @(negedge CLK);
            cycles++;
        end while (bus.BUSY_WAIT && cycles < 200);
        check("access completes", 32'(bus.BUSY_WAIT), 0);
        @(posedge CLK);
        #2;
        bus.READ  = 1'b0;
        bus.WRITE = 1'b0;
    endtask

    initial begin
        int cyc;
        int base;
        bit seen;
        bus.READ = 1'b0;
        bus.WRITE = 1'b0;
        bus.ADDRESS = '0;
        bus.WRITEDATA = '0;
        for (int b = 0; b < 64; b++) mem[b] = $urandom;
        mem[1] = 32'h44332211;
        model_reset();
        repeat (2) @(posedge CLK);
        #2;
        RESET = 1'b0;
        @(negedge CLK);
        check("reset READDATA", 32'(bus.READDATA), 0);
        check("reset BUSY_WAIT", 32'(bus.BUSY_WAIT), 0);
        check("reset MEM_READ", 32'(bus.MEM_READ), 0);
        check("reset MEM_WRITE", 32'(bus.MEM_WRITE), 0);
        check("reset MEM_ADDRESS", 32'(bus.MEM_ADDRESS), 0);
        check("reset MEM_WRITEDATA", bus.MEM_WRITEDATA, 0);

        // Clean read miss with a 3-cycle busy memory.
        mem_lat = 3;
        access(0, 8'h05, 8'h00, cyc);
        check("read miss stall", 32'(cyc), 7);
        check("read miss data", 32'(last_rd), 32'h22);
        check("read miss fetch addr", 32'(last_fetch_addr), 32'h01);
        check("no writeback on clean miss", 32'(mem_wr_cycles), 0);

        // Store hit then load hit, no stall.
        access(1, 8'h06, 8'hAA, cyc);
        check("store hit stall", 32'(cyc), 1);
        access(0, 8'h06, 8'h00, cyc);
        check("load hit stall", 32'(cyc), 1);
        check("load after store", 32'(last_rd), 32'hAA);

        // Conflict miss on a dirty line.
        access(0, 8'h25, 8'h00, cyc);
        check("victim addr", 32'(last_wb_addr), 32'h01);
        check("victim data", last_wb_data, 32'h44AA2211);
        check("conflict fetch addr", 32'(last_fetch_addr), 32'h09);

        // Write-allocate on a clean miss.
        access(1, 8'h10, 8'h5C, cyc);
        check("store miss fetch addr", 32'(last_fetch_addr), 32'h04);
        access(0, 8'h10, 8'h00, cyc);
        check("merged byte", 32'(last_rd), 32'h5C);
        access(0, 8'h13, 8'h00, cyc);
        check("untouched byte", 32'(last_rd), 32'(mem[4][31:24]));

        // Warm all indices with tag 0, then abort a fetch with reset.
        mem_lat = -1;
        for (int i = 0; i < 8; i++) access(0, 8'(i * 4), 8'h00, cyc);
        mem_lat = 5;
        fetch_q.push_back(6'h10);
        @(posedge CLK);
        #2;
        bus.READ = 1'b1;
        bus.ADDRESS = 8'h40;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            seen = bus.MEM_READ;
        end
        check("fetch started before reset", 32'(seen), 1);
        @(posedge CLK);
        #2;
        RESET = 1'b1;
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        @(negedge CLK);
        check("MEM_READ dropped by reset", 32'(bus.MEM_READ), 0);
        check("fresh miss after reset", 32'(bus.BUSY_WAIT), 1);
        #2;
        bus.READ = 1'b0;
        model_reset();
        mem_lat = 0;
        for (int i = 0; i < 8; i++) begin
            access(0, 8'(i * 4), 8'h00, cyc);
            check("line invalid after reset", 32'(cyc > 1), 1);
        end

        // Instant memory: fetch takes exactly two cycles.
        base = mem_rd_cycles;
        access(0, 8'h80, 8'h00, cyc);
        check("instant miss stall", 32'(cyc), 4);
        check("instant fetch cycles", 32'(mem_rd_cycles - base), 2);

        // Random traffic over three tags to mix hits, clean and dirty misses.
        mem_lat = -1;
        for (int n = 0; n < 300; n++) begin
            access(bit'($urandom_range(0, 1)), 8'($urandom_range(0, 95)),
                   8'($urandom), cyc);
        end

        @(negedge CLK);
        check("scoreboard drained", 32'(wb_addr_q.size() + fetch_q.size() + rd_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
